// File: rtl/adc_frame_packer.sv
// Packs four 16-bit ADC samples, qualified by the delayed FIFO read strobe, into one
// 64-bit AXI4-Stream beat. tlast marks the final word of each frame.
module adc_frame_packer #(
  parameter int FRAME_SAMPLES = 1024,
  parameter int RD_LAT        = 1
) (
  input  logic        clk_100m,
  input  logic        rstn_i,
  input  logic        clr,
  input  logic        fifo_rd_en,
  input  logic [15:0] fifo_dout,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        frame_done,
  output logic        overflow,
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_SAMPLES - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  vld_pipe;
  logic        sample_vld;
  logic        frame_end;
  logic [15:0] sample_idx;
  logic [47:0] word_lo;
  logic        push_vld, push_last;
  logic [63:0] push_data;
  logic [63:0] buf_data [2];
  logic [1:0]  buf_last;
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        full, pop, push_ok;

  // The FIFO only promises data RD_LAT cycles after the strobe, so the strobe is delayed to match.
  assign sample_vld = (RD_LAT == 2) ? vld_pipe[1] : vld_pipe[0];

  always_ff @(posedge clk_100m or negedge rstn_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn_i)  vld_pipe <= '0;
    else if (clr) vld_pipe <= '0;
    else          vld_pipe <= {vld_pipe[0], fifo_rd_en};
  end

  always_ff @(posedge clk_100m or negedge rstn_i) begin
    if (!rstn_i)  state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      IDLE:    if (sample_vld) state_nxt = ACTIVE;
      ACTIVE:  if (sample_vld && sample_idx == LAST_IDX) begin
                 state_nxt = IDLE;
                 frame_end = 1'b1;
               end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane is the low two bits of sample_idx; frames are a multiple of 4, so the last sample is lane 3.
  always_ff @(posedge clk_100m or negedge rstn_i) begin
    if (!rstn_i) begin
      sample_idx <= '0;
      word_lo    <= '0;
      push_vld   <= 1'b0;
      push_last  <= 1'b0;
      push_data  <= '0;
    end else if (clr) begin
      sample_idx <= '0;
      push_vld   <= 1'b0;
    end else begin
      push_vld <= 1'b0;
      if (sample_vld) begin
        case (sample_idx[1:0])
          2'd0:    word_lo[15:0]  <= fifo_dout;
          2'd1:    word_lo[31:16] <= fifo_dout;
          2'd2:    word_lo[47:32] <= fifo_dout;
          default: begin
            push_vld  <= 1'b1;
            push_data <= {fifo_dout, word_lo};
            push_last <= frame_end;
          end
        endcase
        sample_idx <= frame_end ? '0 : sample_idx + 16'd1;
      end
    end
  end

  assign full    = (count == 2'd2);
  assign pop     = m_axis_tvalid & m_axis_tready;
  assign push_ok = push_vld & (~full | pop);

  always_ff @(posedge clk_100m or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: the two buffer entries are reset because the head entry drives tdata straight out.
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else if (clr) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= pop & m_axis_tlast;
      if (pop && m_axis_tlast) frame_cnt <= frame_cnt + 16'd1;
      if (push_ok) begin
        buf_data[wr_ptr] <= push_data;
        buf_last[wr_ptr] <= push_last;
        wr_ptr           <= ~wr_ptr;
      end
      // A full buffer with no pop drops the word; the frame position has already advanced.
      if (push_vld && !push_ok) overflow <= 1'b1;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop};
    end
  end

  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = buf_data[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid & buf_last[rd_ptr];

endmodule

// File: tb/tb_adc_frame_packer.sv
// Bench for adc_frame_packer: one instance with RD_LAT=1 and one with RD_LAT=2, a FIFO read-side
// model per instance, a beat monitor, a table of frame runs, and hand sequences for clr and reset.
module tb_adc_frame_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_i;
  logic        clr        [2];
  logic        rd_en      [2];
  logic [15:0] dout       [2];
  logic        tready     [2];
  logic [63:0] tdata      [2];
  logic        tvalid     [2];
  logic        tlast      [2];
  logic        frame_done [2];
  logic        overflow   [2];
  logic [15:0] frame_cnt  [2];

  adc_frame_packer #(.FRAME_SAMPLES(1024), .RD_LAT(1)) dut1 (
    .clk_100m(clk), .rstn_i(rstn_i), .clr(clr[0]), .fifo_rd_en(rd_en[0]), .fifo_dout(dout[0]),
    .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]),
    .m_axis_tlast(tlast[0]), .frame_done(frame_done[0]), .overflow(overflow[0]),
    .frame_cnt(frame_cnt[0]));

  adc_frame_packer #(.FRAME_SAMPLES(1024), .RD_LAT(2)) dut2 (
    .clk_100m(clk), .rstn_i(rstn_i), .clr(clr[1]), .fifo_rd_en(rd_en[1]), .fifo_dout(dout[1]),
    .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]),
    .m_axis_tlast(tlast[1]), .frame_done(frame_done[1]), .overflow(overflow[1]),
    .frame_cnt(frame_cnt[1]));

  // FIFO read side: each strobe returns the next value RD_LAT cycles later.
  bit          h1, h2a, h2b;
  logic [15:0] src_base  [2];
  int          src_start [2];
  int          src_idx   [2] = '{0, 0};

  always @(posedge clk) begin
    h1  = rd_en[0];
    h2b = h2a;
    h2a = rd_en[1];
    #1;
    if (h1) begin
      dout[0] = src_base[0] + 16'(src_idx[0] - src_start[0]);
      src_idx[0]++;
    end else dout[0] = 16'hDEAD;
    if (h2b) begin
      dout[1] = src_base[1] + 16'(src_idx[1] - src_start[1]);
      src_idx[1]++;
    end else dout[1] = 16'hDEAD;
  end

  // Beat monitor: accepted beats, frame_done pulses, and AXIS hold-rule violations.
  logic [64:0] qa[$], qb[$];
  int          fd_cnt     [2] = '{0, 0};
  int          stab_cnt   [2] = '{0, 0};
  bit          prev_stall [2] = '{0, 0};
  bit          prev_clr   [2] = '{0, 0};
  logic [64:0] prev_beat  [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstn_i) prev_stall[d] = 1'b0;
      else begin
        if (tvalid[d] && tready[d]) begin
          if (d == 0) qa.push_back({tlast[d], tdata[d]});
          else        qb.push_back({tlast[d], tdata[d]});
        end
        if (frame_done[d]) fd_cnt[d]++;
        if (prev_stall[d] && !prev_clr[d] &&
            (!tvalid[d] || {tlast[d], tdata[d]} != prev_beat[d])) stab_cnt[d]++;
        prev_stall[d] = tvalid[d] && !tready[d];
        prev_beat[d]  = {tlast[d], tdata[d]};
        prev_clr[d]   = clr[d];
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] word_of(input logic [15:0] base, input int w);
    logic [15:0] s;
    s = base + 16'(4 * w);
    return {s + 16'd3, s + 16'd2, s + 16'd1, s};
  endfunction

  typedef struct {
    string       name;
    int          lat;
    int          rdy_mode;   // 0: always ready, 1: 1-of-8 for 512 cycles, 2: low for cycles 0..12
    bit          gapped;
    logic [15:0] base;
    bit          full;       // every word expected to arrive
    logic        exp_ovf;
    logic [15:0] exp_cnt;
    bit          probe;      // check first-word latency
  } vec_t;

  vec_t vecs [5];

  task automatic run_frame(input int i);
    vec_t        v;
    int          d, q0, fd0, st0, ncyc, errs, prev_w, w;
    logic [15:0] rel;
    logic [64:0] beats[$];
    v      = vecs[i];
    d      = (v.lat == 2) ? 1 : 0;
    q0     = (d == 1) ? qb.size() : qa.size();
    fd0    = fd_cnt[d];
    st0    = stab_cnt[d];
    ncyc   = v.gapped ? 2048 : 1024;
    errs   = 0;
    prev_w = -1;
    src_base[d]  = v.base;
    src_start[d] = src_idx[d];
    for (int c = 0; c < ncyc + 40; c++) begin
      @(posedge clk); #1;
      rd_en[d] = (c < ncyc) && (!v.gapped || (c % 2 == 0));
      case (v.rdy_mode)
        1:       tready[d] = (c >= 512) || (c % 8 == 0);
        2:       tready[d] = (c >= 13);
        default: tready[d] = 1'b1;
      endcase
      if (v.probe && (c == 5 || c == 6)) begin
        @(negedge clk);
        if (c == 5) check({v.name, "_lat_pre"}, 65'(tvalid[d]), 65'(0));
        else check({v.name, "_lat_word0"}, {tvalid[d], tdata[d]}, {1'b1, word_of(v.base, 0)});
      end
    end
    if (d == 1) for (int j = q0; j < qb.size(); j++) beats.push_back(qb[j]);
    else        for (int j = q0; j < qa.size(); j++) beats.push_back(qa[j]);

    if (v.full) check({v.name, "_beats"}, 65'(beats.size()), 65'(256));
    else        check({v.name, "_beats_lt256"}, 65'(beats.size() < 256), 65'(1));
    if (beats.size() == 0) beats.push_back('0);
    foreach (beats[j]) begin
      rel = beats[j][15:0] - v.base;
      w   = int'(rel >> 2);
      if (rel[1:0] != 2'd0 || beats[j][63:0] != word_of(v.base, w) || w <= prev_w ||
          (v.full && w != j) || beats[j][64] != (w == 255)) errs++;
      prev_w = w;
    end
    check({v.name, "_first"}, 65'(beats[0][63:0]), 65'(word_of(v.base, 0)));
    check({v.name, "_order_errs"}, 65'(errs), 65'(0));
    check({v.name, "_last"}, beats[beats.size() - 1], {1'b1, word_of(v.base, 255)});
    check({v.name, "_frame_done"}, 65'(fd_cnt[d] - fd0), 65'(1));
    check({v.name, "_frame_cnt"}, 65'(frame_cnt[d]), 65'(v.exp_cnt));
    check({v.name, "_overflow"}, 65'(overflow[d]), 65'(v.exp_ovf));
    check({v.name, "_axis_hold"}, 65'(stab_cnt[d] - st0), 65'(0));
  endtask

  initial begin
    int qs;
    vecs[0] = '{"s1_full_rate",  1, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd1, 1'b1};
    vecs[1] = '{"s3_stall",      1, 2, 1'b0, 16'h2000, 1'b1, 1'b0, 16'd2, 1'b1};
    vecs[2] = '{"s2_sparse",     1, 1, 1'b0, 16'h4000, 1'b0, 1'b1, 16'd3, 1'b0};
    vecs[3] = '{"s6_lat2_gap",   2, 0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'd1, 1'b0};
    vecs[4] = '{"s4_after_clr",  1, 0, 1'b0, 16'h0100, 1'b1, 1'b0, 16'd1, 1'b0};

    rstn_i = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clr[d] = 1'b0; rd_en[d] = 1'b0; tready[d] = 1'b1;
      src_base[d] = '0; src_start[d] = 0;
    end

    repeat (3) @(negedge clk);
    check("reset_ctrl", 65'({tvalid[0], tlast[0], frame_done[0], overflow[0]}), 65'(0));
    check("reset_tdata", 65'(tdata[0]), 65'(0));
    check("reset_frame_cnt", 65'(frame_cnt[0]), 65'(0));
    check("reset_tvalid_lat2", 65'(tvalid[1]), 65'(0));
    rstn_i = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_frame(i);

    // clr with a word held, a partial word and a sample still in the read pipe
    tready[0]    = 1'b0;
    src_base[0]  = 16'hA000;
    src_start[0] = src_idx[0];
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      rd_en[0] = (c < 6);
      clr[0]   = (c == 6);
    end
    @(negedge clk);
    check("clr_pre_overflow", 65'(overflow[0]), 65'(1));
    @(posedge clk); #1;
    clr[0]    = 1'b0;
    tready[0] = 1'b1;
    qs        = qa.size();
    @(negedge clk);
    check("clr_flush_tvalid", 65'(tvalid[0]), 65'(0));
    check("clr_overflow", 65'(overflow[0]), 65'(0));
    check("clr_frame_cnt", 65'(frame_cnt[0]), 65'(0));
    repeat (10) @(negedge clk);
    check("clr_no_leak", 65'(qa.size() - qs), 65'(0));

    run_frame(4);

    // Asynchronous reset while a beat is stalled and the buffer has overflowed
    tready[0]    = 1'b0;
    src_base[0]  = 16'h7000;
    src_start[0] = src_idx[0];
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      rd_en[0] = (c < 16);
    end
    @(negedge clk);
    check("rst_pre_valid_ovf", 65'({tvalid[0], overflow[0]}), 65'(2'b11));
    rstn_i = 1'b0;
    #1;
    check("rst_mid_ctrl", 65'({tvalid[0], tlast[0], frame_done[0], overflow[0]}), 65'(0));
    check("rst_mid_tdata", 65'(tdata[0]), 65'(0));
    check("rst_mid_frame_cnt", 65'(frame_cnt[0]), 65'(0));
    repeat (2) @(negedge clk);
    rstn_i    = 1'b1;
    tready[0] = 1'b1;
    qs        = qa.size();
    repeat (20) @(negedge clk);
    check("rst_no_leak", 65'(qa.size() - qs), 65'(0));
    check("rst_idle_tvalid", 65'(tvalid[0]), 65'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
